// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, one or two stop bits.
// The bit period comes from a run-time divisor that is latched when a byte is accepted.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [BAUD_W-1:0]    baud,
  input  logic                 tx_en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [3:0]           bit_cnt_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [BAUD_W-1:0] ONE        = BAUD_W'(1);
  localparam logic [3:0]        LAST_DATA  = 4'(DATA_BITS);
  localparam logic [3:0]        FIRST_STOP = 4'(DATA_BITS + 1);

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      cnt_q, cnt_d;
  logic [BAUD_W-1:0]      div_q, div_d;
  logic                   sel_q, sel_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [3:0]             bit_q, bit_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  assign tx_ready    = (state_q == IDLE) && tx_en && rst;
  assign bit_end     = (cnt_q == div_q - ONE);
  assign tx_out      = out_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign bit_cnt_out = bit_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    bit_d   = bit_q;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = START;
          cnt_d   = '0;
          // Divisors of 0 and 1 both mean one clock per bit.
          div_d   = (baud > ONE) ? baud : ONE;
          sel_d   = sel;
          shift_d = tx_data;
          bit_d   = 4'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 4'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            state_d = STOP;
            bit_d   = FIRST_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (sel_q && (bit_q == FIRST_STOP)) begin
            bit_d = bit_q + 4'd1;
          end else begin
            state_d = IDLE;
            bit_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = 4'd0;
      end
    endcase

    // Outputs are registered from next-state so the line changes on the accept edge.
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
      default: out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      sel_q   <= 1'b0;
      shift_q <= '0;
      bit_q   <= 4'd0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, frame shapes, divisor edge cases,
// mid-frame input changes and asynchronous reset during a frame.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [19:0] baud;
  logic        tx_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_out;
  logic        tx_busy;
  logic        tx_done;
  logic [3:0]  bit_cnt_out;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.DATA_BITS(8), .BAUD_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .baud        (baud),
    .tx_en       (tx_en),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .bit_cnt_out (bit_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed observation: {tx_out, tx_busy, tx_done, bit_cnt_out}
  function automatic logic [31:0] obs_vec();
    return {25'd0, tx_out, tx_busy, tx_done, bit_cnt_out};
  endfunction

  // Called on cycle 1 of a frame; walks every frame cycle, ends on the done cycle.
  task automatic frame_check(input string tag, input logic [15:0] bits, input int nbits, input int div);
    for (int i = 0; i < nbits * div; i++) begin
      check($sformatf("%s_c%0d", tag, i + 1), obs_vec(),
            {25'd0, bits[i / div], 1'b1, 1'b0, 4'(i / div)});
      step();
    end
    check({tag, "_done"}, obs_vec(), {25'd0, 1'b1, 1'b0, 1'b1, 4'd0});
  endtask

  task automatic send(input logic [7:0] d, input logic [19:0] b, input logic s);
    tx_data  = d;
    baud     = b;
    sel      = s;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    sel      = 1'b0;
    baud     = 20'd4;
    tx_en    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset and idle
    repeat (3) step();
    check("rst_out", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    tx_en = 1'b1;
    #1;
    check("rst_ready_gated", {31'd0, tx_ready}, 32'd0);
    tx_en = 1'b0;
    rst   = 1'b1;
    repeat (4) step();
    check("idle_out", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    check("idle_ready_en0", {31'd0, tx_ready}, 32'd0);
    tx_en = 1'b1;
    #1;
    check("idle_ready_en1", {31'd0, tx_ready}, 32'd1);

    // Basic frame 0xA5, divisor 4, one stop bit
    send(8'hA5, 20'd4, 1'b0);
    frame_check("a5", 16'b0000_0011_0100_1010, 10, 4);
    check("a5_ready", {31'd0, tx_ready}, 32'd1);
    step();

    // Two stop bits, back-to-back 0x00 then 0xFF with valid held
    tx_data  = 8'h00;
    baud     = 20'd2;
    sel      = 1'b1;
    tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    frame_check("f00", 16'h0600, 11, 2);
    check("f00_ready", {31'd0, tx_ready}, 32'd1);
    step();
    tx_valid = 1'b0;
    frame_check("fff", 16'h07FE, 11, 2);
    step();

    // Divisor 0 and 1 both give one clock per bit
    send(8'h3C, 20'd0, 1'b1);
    frame_check("b0", 16'h0678, 11, 1);
    step();
    send(8'h3C, 20'd1, 1'b1);
    frame_check("b1", 16'h0678, 11, 1);
    step();

    // Mid-frame changes to baud/sel/data and tx_en dropped
    send(8'h5A, 20'd8, 1'b0);
    baud     = 20'd3;
    sel      = 1'b1;
    tx_data  = 8'hFF;
    tx_en    = 1'b0;
    tx_valid = 1'b1;
    frame_check("dist", 16'h02B4, 10, 8);
    check("dist_ready", {31'd0, tx_ready}, 32'd0);
    repeat (3) step();
    check("dist_no_accept", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    tx_valid = 1'b0;
    tx_en    = 1'b1;
    step();

    // Asynchronous reset during data bit 3
    send(8'h00, 20'd4, 1'b0);
    repeat (13) step();
    check("mid_pre", obs_vec(), {25'd0, 1'b0, 1'b1, 1'b0, 4'd3});
    #2;
    rst = 1'b0;
    #1;
    check("mid_async", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    check("mid_ready", {31'd0, tx_ready}, 32'd0);
    step();
    check("mid_hold", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    rst = 1'b1;
    step();
    check("mid_after", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    step();
    check("mid_after2", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    send(8'hA5, 20'd4, 1'b0);
    frame_check("post", 16'b0000_0011_0100_1010, 10, 4);
    step();
    check("post_idle", obs_vec(), {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
